// File: rtl/digit_serial_adder.sv
// digit_serial_adder: handshaked signed adder computing W bits per cycle over N/W cycles.
// Optional subtraction port enabled by defining DSA_SUB_EN.
module digit_serial_adder #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         overflow
`ifdef DSA_SUB_EN
   ,
   input  logic         sub
`endif
);
   localparam int D  = N / W;
   localparam int CW = $clog2(D + 1);
   localparam logic [CW-1:0] LAST = CW'(D - 1);
   if (W < 1 || W > N || N % W != 0) begin : g_bad_params
      $error("digit_serial_adder: N must be a positive multiple of W");
   end
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state;
   logic [N-1:0] a_r, b_r;
   logic [CW-1:0] cnt;
   logic carry;
   logic [W:0] dsum;
   logic [N-1:0] b_eff;
   logic c0;
`ifdef DSA_SUB_EN
   assign b_eff = sub ? ~b : b;
   assign c0    = sub | cin;
`else
   assign b_eff = b;
   assign c0    = cin;
`endif
   // one W-bit ripple slice shared by every digit
   assign dsum = {1'b0, a_r[cnt*W +: W]} + {1'b0, b_r[cnt*W +: W]} + {{W{1'b0}}, carry};
   // control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         overflow  <= 1'b0;
         a_r       <= '0;
         b_r       <= '0;
         cnt       <= '0;
         carry     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  a_r      <= a;
                  b_r      <= b_eff;
                  carry    <= c0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               sum[cnt*W +: W] <= dsum[W-1:0];
               carry           <= dsum[W];
               cnt             <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cout      <= dsum[W];
                  overflow  <= (a_r[N-1] == b_r[N-1]) && (dsum[W-1] != a_r[N-1]);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: table-driven scoreboard bench for digit_serial_adder (N=32, W=8).
module tb_digit_serial_adder;
   localparam int N = 32;
   localparam int W = 8;
   typedef struct {
      logic [N-1:0] a, b;
      logic         cin;
      logic [N-1:0] s;
      logic         c, o;
      int           hold;
   } vec_t;
   typedef struct {
      logic [N-1:0] s;
      logic         c, o;
   } exp_t;
   logic clk = 1'b0;
   logic rst, in_valid, in_ready, cin, out_valid, out_ready, cout, overflow, sub;
   logic [N-1:0] a, b, sum;
   int checks = 0;
   int failures = 0;
   exp_t sb[$];
   vec_t vecs[$];
   digit_serial_adder #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .overflow(overflow)
`ifdef DSA_SUB_EN
      , .sub(sub)
`endif
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci, input logic sb_sub);
      logic [N-1:0] be;
      logic [N:0] t;
      exp_t e;
      be = sb_sub ? ~y : y;
      t = {1'b0, x} + {1'b0, be} + {{N{1'b0}}, (sb_sub | ci)};
      e.s = t[N-1:0];
      e.c = t[N];
      e.o = (x[N-1] == be[N-1]) && (t[N-1] != x[N-1]);
      return e;
   endfunction
   // offer one operation, check latency, scoreboard result, backpressure and return to idle
   task automatic run(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci, input logic sb_sub, input int hold);
      int lat;
      exp_t e;
      a = x; b = y; cin = ci; sub = sb_sub; in_valid = 1'b1;
      out_ready = (hold == 0);
      lat = 0;
      while (!in_ready && lat < 10) begin tick; lat++; end
      chk("in_ready_before_accept", {31'b0, in_ready}, 1);
      tick;
      sb.push_back(model(x, y, ci, sb_sub));
      in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b1;
      lat = 0;
      do begin tick; lat++; end while (!out_valid && lat < 20);
      chk("latency", lat, N / W);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
         return;
      end
      e = sb.pop_front();
      chk("sum", sum, e.s);
      chk("cout", {31'b0, cout}, {31'b0, e.c});
      chk("overflow", {31'b0, overflow}, {31'b0, e.o});
      for (int i = 0; i < hold; i++) begin
         in_valid = (i == 1);
         tick;
         chk("hold_sum", sum, e.s);
         chk("hold_valid", {31'b0, out_valid}, 1);
         chk("hold_in_ready", {31'b0, in_ready}, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      chk("valid_after_handshake", {31'b0, out_valid}, 0);
      chk("in_ready_after_handshake", {31'b0, in_ready}, 1);
      if (hold > 0) begin
         for (int i = 0; i < 6; i++) begin
            tick;
            chk("no_stray_accept", {31'b0, out_valid}, 0);
         end
      end
   endtask
   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      vecs.push_back('{32'd20, 32'd30, 1'b0, 32'd50, 1'b0, 1'b0, 0});
      vecs.push_back('{-32'sd100, -32'sd423, 1'b0, 32'hFFFFFDF5, 1'b1, 1'b0, 0});
      vecs.push_back('{32'd2147483640, 32'd10, 1'b0, 32'h80000002, 1'b0, 1'b1, 0});
      vecs.push_back('{-32'sd2147483640, -32'sd10, 1'b0, 32'h7FFFFFFE, 1'b1, 1'b1, 0});
      vecs.push_back('{32'd40, -32'sd50, 1'b0, 32'hFFFFFFF6, 1'b0, 1'b0, 5});
      vecs.push_back('{32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 0});
      vecs.push_back('{32'h7FFFFFFF, 32'h0, 1'b1, 32'h80000000, 1'b0, 1'b1, 0});
      vecs.push_back('{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 0});
      tick; tick;
      chk("reset_in_ready", {31'b0, in_ready}, 0);
      chk("reset_out_valid", {31'b0, out_valid}, 0);
      chk("reset_sum", sum, 0);
      chk("reset_cout", {31'b0, cout}, 0);
      chk("reset_overflow", {31'b0, overflow}, 0);
      rst = 1'b0;
      tick;
      chk("in_ready_after_reset", {31'b0, in_ready}, 1);
      foreach (vecs[i]) begin
         exp_t e;
         e = model(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
         chk("model_vs_table", {e.s}, vecs[i].s);
         run(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].hold);
      end
      for (int i = 0; i < 6; i++) run($urandom, $urandom, 1'(i), 1'b0, i % 3);
`ifdef DSA_SUB_EN
      run(32'd422, 32'd200, 1'b0, 1'b1, 0);
      run(32'd5, 32'd9, 1'b1, 1'b1, 0);
      run(32'h80000000, 32'd1, 1'b0, 1'b1, 0);
`endif
      // reset pulsed two cycles into an operation discards it
      a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick; tick;
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      tick;
      sb.delete();
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 0);
      chk("rst_sum", sum, 0);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick;
      chk("rst_in_ready_after", {31'b0, in_ready}, 1);
      for (int i = 0; i < 6; i++) begin
         tick;
         chk("rst_no_result", {31'b0, out_valid}, 0);
      end
      run(32'd123, 32'd456, 1'b1, 1'b0, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Multi-cycle signed adder that accepts an N-bit operand pair over a valid/ready handshake. It computes the sum W bits per clock through a single W-bit ripple slice and returns sum, carry-out and signed overflow over a second valid/ready handshake. It is the handshaked, clocked responder counterpart to the purely combinational adder family. It lets upstream stimulus/control logic issue additions and collect results with backpressure, at a fraction of the area of a full-width adder.

## Interface
Parameters:
- N, 32, operand/result width in bits; must be a multiple of W, otherwise elaboration fails.
- W, 8, digit width processed per cycle; 1 ≤ W ≤ N.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept operands.
- a  input  N  signed operand A.
- b  input  N  signed operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  N  signed result.
- cout  output  1  carry out of bit N-1.
- overflow  output  1  signed two's-complement overflow.
- sub  input  1  present only with DSA_SUB_EN; 1 selects A−B.

## Operation
- States:
  - IDLE: in_ready=1; no result pending.
  - BUSY: digits being computed.
  - DONE: out_valid=1; result held.
- Accept: when `in_valid && in_ready` at a rising edge, a, b and cin (and sub) are captured into internal registers. The digit counter clears and the state moves IDLE→BUSY. Input changes after the accept edge have no effect.
- BUSY, each cycle:
  - Add digit i of A and B plus the running carry into sum bits [i*W+W-1 : i*W].
  - Register the new carry.
  - Increment i.
  - After digit N/W−1, move to DONE.
- Result computation:
  - cout is the final carry.
  - overflow = (A[N-1] == Beff[N-1]) && (sum[N-1] != A[N-1]), where Beff is the effective B operand (B, or ~B under subtraction).
- DONE: sum, cout and overflow stay stable while out_valid=1. On `out_valid && out_ready`, move DONE→IDLE.
- Only one operation is in flight at a time.
  - in_ready=0 in BUSY and DONE.
  - in_valid is ignored in BUSY and DONE.
- Arithmetic is modulo 2^N. Sum bits not yet computed are don't-care until out_valid.

## Timing
- Reset:
  - State goes to IDLE.
  - out_valid=0, sum=0, cout=0, overflow=0.
  - in_ready=0 while rst=1; in_ready=1 from the first cycle after rst deasserts.
- Latency: accept at edge k gives out_valid=1 after edge k+N/W. For N=32, W=8 that is 4 cycles; for W=N it is 1 cycle.
- Throughput:
  - Handshake at edge m returns the block to IDLE. in_ready=1 in cycle m+1, so the next accept is at edge m+1 at the earliest.
  - Peak rate is one result per N/W+2 cycles.
- out_ready may be high before out_valid. The handshake completes on the first edge where both are high.
- A reset asserted during BUSY or DONE discards the operation. out_valid=0 and in_ready=0 in the following cycle, then the normal post-reset behaviour applies.
- Simultaneous rst with in_valid or out_ready: reset wins; no accept and no handshake.

## Configuration
- DSA_SUB_EN defined:
  - Port `sub` exists and is captured at accept.
  - With sub=1, Beff = ~b and the carry-in is forced to 1, independent of cin. cout=1 means no borrow.
  - With sub=0, behaviour is identical to the plain adder.
- DSA_SUB_EN undefined:
  - No `sub` port.
  - Beff = b and carry-in = cin.

## Test plan
- N=32, W=8, a=20, b=30, cin=0, out_ready=1: sum=50, cout=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge and lasts 1 cycle.
- a=−100, b=−423 (negative + negative): sum=0xFFFFFDF5 (−523), cout=1, overflow=0.
- a=2147483640, b=10 (positive overflow): sum=0x80000002, cout=0, overflow=1.
- a=−2147483640, b=−10 (negative overflow): sum=0x7FFFFFFE, cout=1, overflow=1.
- Backpressure with a=40, b=−50, out_ready held low 5 cycles after out_valid:
  - sum=0xFFFFFFF6 is stable and in_ready=0 throughout.
  - A second in_valid pulse during this window is not accepted.
  - After the handshake, in_ready=1 in the next cycle.
- Reset and subtraction:
  - rst pulsed 2 cycles after accept gives out_valid=0, sum=0, and in_ready=1 one cycle after rst deasserts.
  - With DSA_SUB_EN, a=422, b=200, sub=1 gives sum=222 and cout=1.
